ex_sequencer: RTL and testbench

EX_SEQUENCER -- requirements
Module: ex_sequencer

---
 rtl/ex_sequencer_pkg.sv | 28 ++
 rtl/ex_serial_shifter.sv | 51 +++++
 rtl/ex_sequencer.sv | 165 ++++++++++++++++
 tb/tb_ex_sequencer.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_sequencer_pkg.sv
// Shared definitions for the execute-stage sequencer: datapath width,
// sequencer states and one-hot funct3 bit positions.
package ex_sequencer_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StExec  = 2'd1,
    StShift = 2'd2
  } state_e;

  // Bit positions inside the one-hot funct3 vector.
  localparam int unsigned F3Add  = 0;
  localparam int unsigned F3Sll  = 1;
  localparam int unsigned F3Slt  = 2;
  localparam int unsigned F3Sltu = 3;
  localparam int unsigned F3Xor  = 4;
  localparam int unsigned F3Sr   = 5;
  localparam int unsigned F3Or   = 6;
  localparam int unsigned F3And  = 7;

  // True for SLL/SRL/SRA encodings (caller qualifies with the ALU class).
  function automatic logic is_shift(input logic [7:0] funct3oh);
    return funct3oh[F3Sll] | funct3oh[F3Sr];
  endfunction

endpackage

// File: rtl/ex_serial_shifter.sv
// Bit-serial shifter: loads an operand and a shift amount, then shifts one
// position per step until the count runs out. done flags the final step.
module ex_serial_shifter
  import ex_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [XLEN-1:0] load_value,
  input  logic [4:0]      load_count,
  input  logic            left,
  input  logic            arith,
  input  logic            step,
  output logic [XLEN-1:0] value,
  output logic            done
);

  logic [XLEN-1:0] value_q;
  logic [4:0]      count_q;
  logic            left_q;
  logic            arith_q;

  // Operand/count register: load on accept, shift one bit per step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= '0;
      count_q <= 5'd0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else if (load) begin
      value_q <= load_value;
      count_q <= load_count;
      left_q  <= left;
      arith_q <= arith;
    end else if (step && (count_q != 5'd0)) begin
      if (left_q) begin
        value_q <= {value_q[XLEN-2:0], 1'b0};
      end else begin
        value_q <= {arith_q & value_q[XLEN-1], value_q[XLEN-1:1]};
      end
      count_q <= count_q - 5'd1;
    end
  end

  // The step taken while the count is 1 is the last one.
  always_comb begin
    value = value_q;
    done  = (count_q == 5'd1);
  end

endmodule

// File: rtl/ex_sequencer.sv
// Execute-stage sequencer: holds one decoded op, presents its operands to
// the ALU, returns the result over a valid/ready handshake and raises a
// one-cycle redirect for taken branches.
// Optional macro SERIAL_SHIFT_EN: shifts run on a local bit-serial shifter
// (one bit per cycle) instead of the ALU.
module ex_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_isALUimm,
  input  logic            in_isALUreg,
  input  logic            in_isBranch,
  input  logic [7:0]      in_funct3oh,
  input  logic [6:0]      in_funct7,
  output logic            alu_isALUimm,
  output logic            alu_isALUreg,
  output logic            alu_isBranch,
  output logic [7:0]      alu_funct3oh,
  output logic [6:0]      alu_funct7,
  output logic [XLEN-1:0] alu_rs1,
  output logic [XLEN-1:0] alu_rs2,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_correct,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            flush
);
  import ex_sequencer_pkg::*;

  state_e          state_q, state_d, accept_state;
  logic            first_q, first_d;
  logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q;
  logic            is_alu_imm_q, is_alu_reg_q, is_branch_q;
  logic [7:0]      funct3oh_q;
  logic [6:0]      funct7_q;
  logic            accept;
  logic            shift_done;
  logic [XLEN-1:0] result;

`ifdef SERIAL_SHIFT_EN
  logic            in_shift;
  logic [4:0]      in_shamt;
  logic            held_shift;
  logic [XLEN-1:0] shift_value;

  // Classify the incoming op; the shift amount comes from operand b.
  always_comb begin
    in_shift   = (in_isALUimm | in_isALUreg) & is_shift(in_funct3oh);
    in_shamt   = (in_isALUimm | in_isBranch) ? in_imm[4:0] : in_rs2[4:0];
    held_shift = (is_alu_imm_q | is_alu_reg_q) & is_shift(funct3oh_q);
  end

  ex_serial_shifter u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept & in_shift),
    .load_value (in_rs1),
    .load_count (in_shamt),
    .left       (in_funct3oh[F3Sll]),
    .arith      (in_funct7[5]),
    .step       (state_q == StShift),
    .value      (shift_value),
    .done       (shift_done)
  );
`else
  assign shift_done = 1'b0;
`endif

  // Handshake: a held result must drain before a new op can enter.
  always_comb begin
    in_ready = !flush && ((state_q == StIdle) || ((state_q == StExec) && out_ready));
    accept   = in_valid && in_ready;
  end

  // Next state and first-EXEC-cycle marker; flush overrides everything.
  always_comb begin
    state_d      = state_q;
    accept_state = StExec;
`ifdef SERIAL_SHIFT_EN
    // A zero shift amount needs no serial steps: the result is rs1.
    if (in_shift && (in_shamt != 5'd0)) begin
      accept_state = StShift;
    end
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = accept_state;
      end
      StExec: begin
        if (out_ready) state_d = accept ? accept_state : StIdle;
      end
      StShift: begin
        if (shift_done) state_d = StExec;
      end
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
    first_d = (state_d == StExec) && (accept || (state_q == StShift));
  end

  // State register and operand latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      first_q      <= 1'b0;
      pc_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      imm_q        <= '0;
      is_alu_imm_q <= 1'b0;
      is_alu_reg_q <= 1'b0;
      is_branch_q  <= 1'b0;
      funct3oh_q   <= 8'd0;
      funct7_q     <= 7'd0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      if (accept) begin
        pc_q         <= in_pc;
        rs1_q        <= in_rs1;
        rs2_q        <= in_rs2;
        imm_q        <= in_imm;
        is_alu_imm_q <= in_isALUimm;
        is_alu_reg_q <= in_isALUreg;
        is_branch_q  <= in_isBranch;
        funct3oh_q   <= in_funct3oh;
        funct7_q     <= in_funct7;
      end
    end
  end

  // ALU drive from the held op; operand b is the immediate for imm and branch ops.
  always_comb begin
    alu_isALUimm = is_alu_imm_q;
    alu_isALUreg = is_alu_reg_q;
    alu_isBranch = is_branch_q;
    alu_funct3oh = funct3oh_q;
    alu_funct7   = funct7_q;
    alu_rs1      = rs1_q;
    alu_rs2      = (is_alu_imm_q | is_branch_q) ? imm_q : rs2_q;
  end

  // Result and redirect outputs; held operands keep them stable under stall.
  always_comb begin
    result = is_branch_q ? '0 : alu_result;
`ifdef SERIAL_SHIFT_EN
    if (held_shift) result = shift_value;
`endif
    out_valid      = (state_q == StExec);
    out_result     = out_valid ? result : '0;
    redirect_valid = out_valid && first_q && is_branch_q && alu_correct && !flush;
    redirect_pc    = pc_q + imm_q;
  end

endmodule

// File: tb/tb_ex_sequencer.sv
// Self-checking bench for ex_sequencer: directed scenarios with literal
// expectations followed by randomized traffic against an op-level model.
module tb_ex_sequencer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        isimm;
    logic        isreg;
    logic        isbr;
    logic [7:0]  f3oh;
    logic [6:0]  f7;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
  logic        in_isALUimm, in_isALUreg, in_isBranch;
  logic [7:0]  in_funct3oh;
  logic [6:0]  in_funct7;
  logic        alu_isALUimm, alu_isALUreg, alu_isBranch;
  logic [7:0]  alu_funct3oh;
  logic [6:0]  alu_funct7;
  logic [31:0] alu_rs1, alu_rs2, alu_result;
  logic        alu_correct;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;

  ex_sequencer #(.XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_rs1         (in_rs1),
    .in_rs2         (in_rs2),
    .in_imm         (in_imm),
    .in_isALUimm    (in_isALUimm),
    .in_isALUreg    (in_isALUreg),
    .in_isBranch    (in_isBranch),
    .in_funct3oh    (in_funct3oh),
    .in_funct7      (in_funct7),
    .alu_isALUimm   (alu_isALUimm),
    .alu_isALUreg   (alu_isALUreg),
    .alu_isBranch   (alu_isBranch),
    .alu_funct3oh   (alu_funct3oh),
    .alu_funct7     (alu_funct7),
    .alu_rs1        (alu_rs1),
    .alu_rs2        (alu_rs2),
    .alu_result     (alu_result),
    .alu_correct    (alu_correct),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // RV32 integer ALU semantics selected by one-hot funct3.
  function automatic logic [31:0] alu_fn(input logic [7:0] f3oh, input logic [6:0] f7,
                                         input logic isreg, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (f3oh)
      8'h01:   return (isreg && f7[5]) ? a - b : a + b;
      8'h02:   return a << sh;
      8'h04:   return {31'd0, $signed(a) < $signed(b)};
      8'h08:   return {31'd0, a < b};
      8'h10:   return a ^ b;
      8'h20:   return f7[5] ? $unsigned($signed(a) >>> sh) : a >> sh;
      8'h40:   return a | b;
      8'h80:   return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic br_taken(input logic [7:0] f3oh, input logic [31:0] a,
                                    input logic [31:0] b);
    case (f3oh)
      8'h01:   return a == b;
      8'h02:   return a != b;
      8'h10:   return $signed(a) < $signed(b);
      8'h20:   return $signed(a) >= $signed(b);
      8'h40:   return a < b;
      8'h80:   return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] op_b(input op_t op);
    return (op.isimm || op.isbr) ? op.imm : op.rs2;
  endfunction

  function automatic logic [31:0] op_result(input op_t op);
    if (op.isbr) return 32'd0;
    return alu_fn(op.f3oh, op.f7, op.isreg, op.rs1, op_b(op));
  endfunction

  // Extra cycles between accept and presentation.
  function automatic int op_delay(input op_t op);
`ifdef SERIAL_SHIFT_EN
    logic [31:0] b;
    b = op_b(op);
    if ((op.isimm || op.isreg) && (op.f3oh == 8'h02 || op.f3oh == 8'h20)) return int'(b[4:0]);
`endif
    return 0;
  endfunction

  function automatic op_t mk_op(input logic [31:0] pc, input logic [31:0] rs1,
                                input logic [31:0] rs2, input logic [31:0] imm,
                                input int cls, input logic [2:0] f3, input logic [6:0] f7);
    op_t op;
    op.pc    = pc;
    op.rs1   = rs1;
    op.rs2   = rs2;
    op.imm   = imm;
    op.isimm = (cls == 0);
    op.isreg = (cls == 1);
    op.isbr  = (cls == 2);
    op.f3oh  = 8'd1 << f3;
    op.f7    = f7;
    return op;
  endfunction

  function automatic op_t rand_op();
    int cls;
    logic [2:0] f3;
    logic [31:0] rs1, rs2, imm;
    logic [6:0] f7;
    cls = int'($urandom_range(0, 2));
    f3  = 3'($urandom_range(0, 7));
    if (cls == 2 && (f3 == 3'd2 || f3 == 3'd3)) f3 = f3 + 3'd4;
    rs1 = $urandom();
    rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom();
    imm = $urandom();
    if (cls == 0 && (f3 == 3'd1 || f3 == 3'd5)) imm = {27'd0, 5'($urandom_range(0, 12))};
    if (cls == 1 && (f3 == 3'd1 || f3 == 3'd5)) rs2 = {27'd0, 5'($urandom_range(0, 12))};
    f7 = 7'd0;
    if (cls != 2 && f3 == 3'd5 && $urandom_range(0, 1) == 1) f7 = 7'h20;
    if (cls == 1 && f3 == 3'd0 && $urandom_range(0, 1) == 1) f7 = 7'h20;
    return mk_op(32'($urandom()), rs1, rs2, imm, cls, f3, f7);
  endfunction

  task automatic drive(input op_t op, input logic v);
    in_pc       = op.pc;
    in_rs1      = op.rs1;
    in_rs2      = op.rs2;
    in_imm      = op.imm;
    in_isALUimm = op.isimm;
    in_isALUreg = op.isreg;
    in_isBranch = op.isbr;
    in_funct3oh = op.f3oh;
    in_funct7   = op.f7;
    in_valid    = v;
  endtask

  // Op-level model: at most one op held, visible after its delay elapses.
  logic m_has   = 1'b0;
  logic m_first = 1'b0;
  int   m_delay = 0;
  op_t  m_op    = '0;
  logic m_pres;
  logic exp_in_ready;

  always_comb begin
    m_pres       = m_has && (m_delay == 0);
    exp_in_ready = !flush && (!m_has || (m_pres && out_ready));
  end

  // External ALU: result from the DUT's operands, branch outcome from the held op.
  always_comb begin
    alu_result  = alu_fn(alu_funct3oh, alu_funct7, alu_isALUreg, alu_rs1, alu_rs2);
    alu_correct = m_has && m_op.isbr && br_taken(m_op.f3oh, m_op.rs1, m_op.rs2);
  end

  // Advance the model with the inputs seen at this edge.
  always @(posedge clk) begin
    op_t  cur;
    logic pres, acc;
    cur.pc    = in_pc;
    cur.rs1   = in_rs1;
    cur.rs2   = in_rs2;
    cur.imm   = in_imm;
    cur.isimm = in_isALUimm;
    cur.isreg = in_isALUreg;
    cur.isbr  = in_isBranch;
    cur.f3oh  = in_funct3oh;
    cur.f7    = in_funct7;
    pres = m_has && (m_delay == 0);
    acc  = in_valid && !flush && (!m_has || (pres && out_ready));
    if (!rst_n) begin
      m_has   = 1'b0;
      m_first = 1'b0;
      m_delay = 0;
    end else if (flush) begin
      m_has = 1'b0;
    end else begin
      if (pres) m_first = 1'b0;
      if (m_has && m_delay > 0) m_delay = m_delay - 1;
      if (pres && out_ready) m_has = 1'b0;
      if (acc) begin
        m_has   = 1'b1;
        m_op    = cur;
        m_delay = op_delay(cur);
        m_first = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic exp_redir;
    if (chk_en) begin
      exp_redir = m_pres && m_first && m_op.isbr && !flush &&
                  br_taken(m_op.f3oh, m_op.rs1, m_op.rs2);
      chk1("in_ready", in_ready, exp_in_ready);
      chk1("out_valid", out_valid, m_pres);
      chk1("redirect_valid", redirect_valid, exp_redir);
      if (m_pres) begin
        chk("out_result", out_result, op_result(m_op));
        chk("alu_rs1", alu_rs1, m_op.rs1);
        chk("alu_rs2", alu_rs2, op_b(m_op));
        if (m_op.isbr) chk("redirect_pc", redirect_pc, m_op.pc + m_op.imm);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive('0, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst out_valid", out_valid, 1'b0);
    chk1("rst redirect_valid", redirect_valid, 1'b0);
    chk("rst out_result", out_result, 32'd0);
    chk("rst redirect_pc", redirect_pc, 32'd0);
    chk_en = 1'b1;
    next_cycle();
    rst_n = 1'b1;

    // ADDI 5 + 7
    drive(mk_op(32'h0, 32'd5, 32'd0, 32'd7, 0, 3'd0, 7'd0), 1'b1);
    @(negedge clk);
    chk1("addi in_ready", in_ready, 1'b1);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk1("addi out_valid", out_valid, 1'b1);
    chk("addi result", out_result, 32'd12);
    next_cycle();
    @(negedge clk);
    chk1("addi back to idle", out_valid, 1'b0);

    // BEQ taken: one-cycle redirect even while stalled
    next_cycle();
    drive(mk_op(32'h100, 32'd3, 32'd3, 32'h20, 2, 3'd0, 7'd0), 1'b1);
    next_cycle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk1("beq redirect", redirect_valid, 1'b1);
    chk("beq redirect_pc", redirect_pc, 32'h120);
    chk("beq result", out_result, 32'd0);
    next_cycle();
    out_ready = 1'b1;
    @(negedge clk);
    chk1("beq pulse ends", redirect_valid, 1'b0);
    chk1("beq still held", out_valid, 1'b1);
    next_cycle();
    drive(mk_op(32'h100, 32'd3, 32'd4, 32'h20, 2, 3'd0, 7'd0), 1'b1);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk1("beq not taken", redirect_valid, 1'b0);
    chk1("beq nt out_valid", out_valid, 1'b1);

    // ADD 1 + 2 stalled three cycles, next op waits then enters on release
    next_cycle();
    drive(mk_op(32'h0, 32'd1, 32'd2, 32'd0, 1, 3'd0, 7'd0), 1'b1);
    out_ready = 1'b0;
    next_cycle();
    drive(mk_op(32'h0, 32'd10, 32'd0, 32'd1, 0, 3'd0, 7'd0), 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("stall out_valid", out_valid, 1'b1);
      chk("stall result", out_result, 32'd3);
      chk1("stall in_ready", in_ready, 1'b0);
      next_cycle();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk1("release in_ready", in_ready, 1'b1);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("second op result", out_result, 32'd11);

    // Flush with same-cycle in_valid
    next_cycle();
    drive(mk_op(32'h0, 32'd1, 32'd0, 32'd1, 0, 3'd0, 7'd0), 1'b1);
    flush = 1'b1;
    @(negedge clk);
    chk1("flush blocks accept", in_ready, 1'b0);
    next_cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk1("flush nothing accepted", out_valid, 1'b0);

    // Flush while a taken branch is held
    next_cycle();
    drive(mk_op(32'h200, 32'd9, 32'd9, 32'h40, 2, 3'd0, 7'd0), 1'b1);
    out_ready = 1'b0;
    next_cycle();
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    chk1("flush kills redirect", redirect_valid, 1'b0);
    chk1("flush in_ready", in_ready, 1'b0);
    next_cycle();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk1("flush idle out_valid", out_valid, 1'b0);
    chk1("flush idle in_ready", in_ready, 1'b1);

`ifdef SERIAL_SHIFT_EN
    // SRAI by 4, then by 0
    next_cycle();
    drive(mk_op(32'h0, 32'h8000_0000, 32'd0, 32'd4, 0, 3'd5, 7'h20), 1'b1);
    next_cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("srai busy in_ready", in_ready, 1'b0);
      chk1("srai busy out_valid", out_valid, 1'b0);
      next_cycle();
    end
    @(negedge clk);
    chk1("srai out_valid", out_valid, 1'b1);
    chk("srai result", out_result, 32'hF800_0000);
    next_cycle();
    drive(mk_op(32'h0, 32'h8000_0000, 32'd0, 32'd0, 0, 3'd5, 7'h20), 1'b1);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk1("srai0 out_valid", out_valid, 1'b1);
    chk("srai0 result", out_result, 32'h8000_0000);
`endif

    // Reset while an op is in flight
    next_cycle();
    drive(mk_op(32'h0, 32'd1, 32'd0, 32'd10, 0, 3'd1, 7'd0), 1'b1);
    out_ready = 1'b0;
    next_cycle();
    in_valid = 1'b0;
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk1("mid-op reset out_valid", out_valid, 1'b0);
    chk1("mid-op reset in_ready", in_ready, 1'b1);
    out_ready = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      next_cycle();
      drive(rand_op(), $urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 15) == 0);
      rst_n     = ($urandom_range(0, 499) != 0);
    end
    next_cycle();
    drive('0, 1'b0);
    flush = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
